mem_stage: RTL and testbench
============================

# mem_stage

Memory stage of the five-stage CPU pipeline. Sits directly downstream of the execute stage (`EX`) and upstream of writeback. It owns the EX/MEM and MEM/WB pipeline registers, a word-addressed data memory with configurable access latency, and the multi-cycle access FSM. It drives the system-wide `stall` that freezes every upstream stage while a load or store is in progress.

## Interface
- `ADDR_W`, default 14: data memory address width; depth is 2^ADDR_W 32-bit words.
- `MEM_LAT`, default 2: extra cycles a load or store occupies MEM; must be ≥1.

Ports:
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `EX_valid` in 1: EX carries a real instruction; 0 marks a bubble.
- `EX_ALU_result` in 32: ALU result; this is the address for loads and stores.
- `EX_t_data` in 32: store data.
- `EX_mem_re` in 1: the instruction is a load.
- `EX_mem_we` in 1: the instruction is a store.
- `EX_dst_reg` in 5: destination register.
- `EX_reg_we` in 1: the instruction writes the register file.
- `EX_hlt` in 1: the instruction is a halt.
- `stall` out 1: freeze PC, IF, ID, EX and the EX/MEM register.
- `WB_we` out 1: register-file write enable to writeback.
- `WB_dst_reg_WB` out 5: writeback destination register.
- `WB_dst_reg_data_WB` out 32: writeback data.
- `WB_hlt` out 1: sticky halt indication, driven to the CPU `hlt`.

## Operation
- **EX/MEM register.** Captures every `EX_*` input on each edge where `stall`=0. It holds its value while `stall`=1.
- **Memory op.** A memory op is present when `m_valid & (m_re | m_we)`.
- **Conflicting flags.** If both `m_re` and `m_we` are set, the store wins. No read occurs, and the register write, if enabled, uses the ALU result.
- **Address.** The address is `m_alu[ADDR_W-1:0]`. Upper bits are ignored, so addresses wrap modulo the depth.
- **FSM states:** IDLE, BUSY, DONE, plus a counter `cnt` with width ceil(log2(MEM_LAT+1)).
  - IDLE: if a memory op is present, go to BUSY and start the access. Otherwise remain in IDLE.
  - BUSY: `cnt` increments each cycle. When `cnt` reaches MEM_LAT−1, go to DONE.
  - DONE: return to IDLE and clear `cnt`. The next EX/MEM contents are evaluated in the following cycle.
- **Stall.** `stall` = (IDLE & memory op present) | BUSY. It is combinational from registered state only, with no path from `EX_*` inputs.
- **Store commit.** A store writes memory exactly once, at the edge leaving IDLE.
- **Load read.** A load samples memory at that same edge (synchronous read) into a read-data register, which holds its value until DONE.
- **MEM/WB register, normal cycle.** When `stall`=0 it captures:
  - `WB_we` = `m_valid & m_reg_we`.
  - `WB_dst_reg_WB` = `m_dst`.
  - `WB_dst_reg_data_WB` = `m_re & ~m_we` ? read data : `m_alu`.
- **MEM/WB register, stalled cycle.** When `stall`=1 it captures a bubble: `WB_we`=0, and the other fields hold. This prevents duplicate register writes.
- **Halt.** `WB_hlt` sets when a valid halt passes into MEM/WB. It stays at 1 until reset. Instructions behind the halt still flow.
- **Memory contents.** Memory is not reset. Contents are undefined until written.

## Timing
- **Reset.** Asynchronous, active low. On assertion all outputs go to 0: `stall`, `WB_we`, `WB_dst_reg_WB`, `WB_dst_reg_data_WB`, `WB_hlt`. The FSM goes to IDLE, `cnt`=0, and the EX/MEM valid bit is 0.
- **Non-memory instruction.** Occupies MEM for 1 cycle. Its result appears on `WB_*` one edge after it enters EX/MEM.
- **Load or store.** Occupies MEM for MEM_LAT+1 cycles.
  - `stall` is high for the first MEM_LAT cycles.
  - In DONE, `stall` is low; at the end of DONE the op moves to MEM/WB and the next instruction enters EX/MEM.
  - With MEM_LAT=2, load data reaches `WB_dst_reg_data_WB` 3 edges after the load enters EX/MEM.
- **Back-to-back memory ops.** Each op pays the full MEM_LAT+1 cycles. There is no overlap.
- **Store followed by load to the same address.** The load returns the stored value, because the store has committed before the load leaves IDLE.
- **Reset mid-access.** The access is abandoned, the FSM returns to IDLE, and `stall` drops immediately.
  - A store already committed remains in memory.
  - A store not yet committed is not performed.
- **Bubbles.** A bubble (`EX_valid`=0) with memory flags set never stalls and never writes.

## Test plan
- **Reset:** assert `rst_n`=0 mid-BUSY → all outputs 0 asynchronously; after release, `stall`=0 and the FSM is in IDLE.
- **ALU passthrough:** ADD with result 0x0000_1234, dst 7 → next edge `WB_we`=1, `WB_dst_reg_WB`=7, `WB_dst_reg_data_WB`=0x1234; `stall` never high.
- **Store then load, MEM_LAT=2:** store 0xDEAD_BEEF to address 0x10, then load 0x10 into r3 →
  - `stall` high for exactly 2 cycles per op, with no `WB_we` pulse during stall.
  - r3 data 0xDEADBEEF appears 3 edges after the load enters MEM.
- **Address wrap:** store to 0x0000_4005 with ADDR_W=14, then load 0x0005 → returns the stored value.
- **Conflicting flags:** re=we=1 with dst write → memory written, and WB data equals the ALU result.
- **Halt:** halt, then ADD → `WB_hlt` rises with the halt and stays 1; the ADD still writes back on the next edge.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM and MEM/WB pipeline registers, word-addressed data
// memory and the multi-cycle access FSM that stalls the upstream pipeline.
module mem_stage #(
  parameter int ADDR_W  = 14,
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_valid,
  input  logic [31:0] EX_ALU_result,
  input  logic [31:0] EX_t_data,
  input  logic        EX_mem_re,
  input  logic        EX_mem_we,
  input  logic [4:0]  EX_dst_reg,
  input  logic        EX_reg_we,
  input  logic        EX_hlt,
  output logic        stall,
  output logic        WB_we,
  output logic [4:0]  WB_dst_reg_WB,
  output logic [31:0] WB_dst_reg_data_WB,
  output logic        WB_hlt
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               m_valid;
  logic [31:0]        m_alu;
  logic [31:0]        m_tdata;
  logic               m_re;
  logic               m_we;
  logic [4:0]         m_dst;
  logic               m_reg_we;
  logic               m_hlt;

  logic [31:0]        mem [2**ADDR_W];
  logic [31:0]        rdata;
  logic [ADDR_W-1:0]  addr;
  logic               mem_op;
  logic               access_go;

  assign addr      = m_alu[ADDR_W-1:0];
  assign mem_op    = m_valid & (m_re | m_we);
  assign access_go = (state == IDLE) & mem_op;
  assign stall     = access_go | (state == BUSY);

  // EX/MEM pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_alu    <= '0;
      m_tdata  <= '0;
      m_re     <= 1'b0;
      m_we     <= 1'b0;
      m_dst    <= '0;
      m_reg_we <= 1'b0;
      m_hlt    <= 1'b0;
    end else if (!stall) begin
      m_valid  <= EX_valid;
      m_alu    <= EX_ALU_result;
      m_tdata  <= EX_t_data;
      m_re     <= EX_mem_re;
      m_we     <= EX_mem_we;
      m_dst    <= EX_dst_reg;
      m_reg_we <= EX_reg_we;
      m_hlt    <= EX_hlt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The IDLE cycle is the first stalled cycle, so cnt leaves IDLE at 1 and
  // BUSY covers the remaining MEM_LAT-1 stalled cycles (none when MEM_LAT=1).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (mem_op) begin
          if (MEM_LAT == 1) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = CNT_W'(1);
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_W'(MEM_LAT - 1)) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Store wins over load when both flags are set
  always_ff @(posedge clk) begin
    if (access_go && m_we) mem[addr] <= m_tdata;
    if (access_go && m_re && !m_we) rdata <= mem[addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_we              <= 1'b0;
      WB_dst_reg_WB      <= '0;
      WB_dst_reg_data_WB <= '0;
      WB_hlt             <= 1'b0;
    end else if (!stall) begin
      WB_we              <= m_valid & m_reg_we;
      WB_dst_reg_WB      <= m_dst;
      WB_dst_reg_data_WB <= (m_re & ~m_we) ? rdata : m_alu;
      WB_hlt             <= WB_hlt | (m_valid & m_hlt);
    end else begin
      WB_we <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage against a transaction-level
// model: per-instruction occupancy, memory as an associative array.
module tb_mem_stage;

  localparam int ADDR_W  = 14;
  localparam int MEM_LAT = 2;

  logic        clk;
  logic        rst_n;
  logic        EX_valid;
  logic [31:0] EX_ALU_result;
  logic [31:0] EX_t_data;
  logic        EX_mem_re;
  logic        EX_mem_we;
  logic [4:0]  EX_dst_reg;
  logic        EX_reg_we;
  logic        EX_hlt;
  logic        stall;
  logic        WB_we;
  logic [4:0]  WB_dst_reg_WB;
  logic [31:0] WB_dst_reg_data_WB;
  logic        WB_hlt;

  mem_stage #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .EX_valid           (EX_valid),
    .EX_ALU_result      (EX_ALU_result),
    .EX_t_data          (EX_t_data),
    .EX_mem_re          (EX_mem_re),
    .EX_mem_we          (EX_mem_we),
    .EX_dst_reg         (EX_dst_reg),
    .EX_reg_we          (EX_reg_we),
    .EX_hlt             (EX_hlt),
    .stall              (stall),
    .WB_we              (WB_we),
    .WB_dst_reg_WB      (WB_dst_reg_WB),
    .WB_dst_reg_data_WB (WB_dst_reg_data_WB),
    .WB_hlt             (WB_hlt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit [31:0] alu;
    bit [31:0] tdata;
    bit        re;
    bit        we;
    bit [4:0]  dst;
    bit        reg_we;
    bit        hlt;
  } instr_t;

  typedef struct {
    bit        we;
    bit [4:0]  dst;
    bit [31:0] data;
    bit        chk_fields;
    bit        chk_data;
    bit        hlt;
  } wb_t;

  bit [31:0] ref_mem [int];
  bit        hlt_seen;
  int        checks;
  int        errors;
  wb_t       pend;
  bit        have_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic instr_t mk(input bit valid, input bit [31:0] alu, input bit [31:0] tdata,
                                input bit re, input bit we, input bit [4:0] dst,
                                input bit reg_we, input bit hlt);
    instr_t i;
    i.valid = valid; i.alu = alu; i.tdata = tdata; i.re = re; i.we = we;
    i.dst = dst; i.reg_we = reg_we; i.hlt = hlt;
    return i;
  endfunction

  // Architectural effect of one instruction on memory, halt and writeback
  task automatic model(input instr_t i, output wb_t w);
    int k;
    k = int'(i.alu[ADDR_W-1:0]);
    w.we         = i.valid & i.reg_we;
    w.dst        = i.dst;
    w.chk_fields = i.valid;
    w.chk_data   = i.valid;
    w.data       = i.alu;
    if (i.valid && i.we) ref_mem[k] = i.tdata;
    if (i.valid && i.re && !i.we) begin
      if (ref_mem.exists(k)) w.data = ref_mem[k];
      else w.chk_data = 1'b0;
    end
    if (i.valid && i.hlt) hlt_seen = 1'b1;
    w.hlt = hlt_seen;
  endtask

  task automatic drive(input instr_t i);
    EX_valid      = i.valid;
    EX_ALU_result = i.alu;
    EX_t_data     = i.tdata;
    EX_mem_re     = i.re;
    EX_mem_we     = i.we;
    EX_dst_reg    = i.dst;
    EX_reg_we     = i.reg_we;
    EX_hlt        = i.hlt;
  endtask

  task automatic check_wb();
    if (have_pend) begin
      chk("wb_we", WB_we, pend.we);
      chk("wb_hlt", WB_hlt, pend.hlt);
      if (pend.chk_fields) chk("wb_dst", WB_dst_reg_WB, pend.dst);
      if (pend.chk_data) chk("wb_data", WB_dst_reg_data_WB, pend.data);
    end
  endtask

  task automatic run(input instr_t i);
    wb_t w;
    bit  is_mem;
    int  lat;
    is_mem = i.valid & (i.re | i.we);
    lat    = is_mem ? MEM_LAT + 1 : 1;
    model(i, w);
    @(negedge clk);
    drive(i);
    @(posedge clk);
    #1;
    check_wb();
    chk("stall_entry", stall, is_mem);
    pend      = w;
    have_pend = 1'b1;
    for (int j = 1; j < lat; j++) begin
      @(posedge clk);
      #1;
      chk("stall_hold", stall, j < MEM_LAT);
      chk("wb_we_in_stall", WB_we, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_stall"}, stall, 1'b0);
    chk({tag, "_we"}, WB_we, 1'b0);
    chk({tag, "_dst"}, WB_dst_reg_WB, 5'd0);
    chk({tag, "_data"}, WB_dst_reg_data_WB, 32'd0);
    chk({tag, "_hlt"}, WB_hlt, 1'b0);
  endtask

  // Store aborted by reset after `edges` edges in MEM; commit happens on the 2nd edge
  task automatic reset_during_store(input instr_t st, input int edges, input string tag);
    @(negedge clk);
    drive(st);
    @(posedge clk);
    #1;
    check_wb();
    chk({tag, "_stall_pre"}, stall, 1'b1);
    for (int j = 1; j < edges; j++) @(posedge clk);
    if (edges >= 2) ref_mem[int'(st.alu[ADDR_W-1:0])] = st.tdata;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(tag);
    have_pend = 1'b0;
    hlt_seen  = 1'b0;
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    #1;
    chk({tag, "_stall_post"}, stall, 1'b0);
  endtask

  initial begin
    instr_t    i;
    bit [31:0] r;
    bit [13:0] a;
    int        kind;

    checks    = 0;
    errors    = 0;
    hlt_seen  = 1'b0;
    have_pend = 1'b0;
    rst_n     = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    run(mk(1, 32'h0000_1234, 0, 0, 0, 5'd7, 1, 0));            // ADD -> r7
    run(mk(1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 1, 5'd0, 0, 0)); // store
    run(mk(1, 32'h0000_0010, 0, 1, 0, 5'd3, 1, 0));            // load r3
    run(mk(1, 32'h0000_4005, 32'hCAFE_0005, 0, 1, 5'd0, 0, 0)); // wrapped store
    run(mk(1, 32'h0000_0005, 0, 1, 0, 5'd4, 1, 0));            // load r4
    run(mk(1, 32'h0000_0033, 32'h1111_2222, 1, 1, 5'd9, 1, 0)); // conflict
    run(mk(1, 32'h0000_0033, 0, 1, 0, 5'd10, 1, 0));
    run(mk(0, 32'h0000_0010, 32'h0, 1, 1, 5'd11, 1, 0));       // bubble with flags
    run(mk(1, 32'h0000_0010, 0, 1, 0, 5'd12, 1, 0));
    run(mk(1, 32'h0000_0000, 0, 0, 0, 5'd0, 0, 1));            // halt
    run(mk(1, 32'h0000_0055, 0, 0, 0, 5'd2, 1, 0));            // ADD after halt
    run(mk(1, 32'h0000_0066, 0, 0, 0, 5'd5, 1, 0));

    for (int n = 0; n < 80; n++) begin
      r    = $urandom;
      a    = 14'($urandom_range(0, 31));
      kind = $urandom_range(0, 3);
      i    = mk($urandom_range(0, 9) != 0, {r[31:14], a}, $urandom, 0, 0,
                5'($urandom_range(0, 31)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) == 0);
      case (kind)
        0: i.alu = $urandom;
        1: i.we  = 1'b1;
        2: i.re  = 1'b1;
        default: begin i.re = 1'b1; i.we = 1'b1; end
      endcase
      run(i);
    end
    run(mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Committed store survives reset; uncommitted one is dropped
    run(mk(1, 32'h0000_0020, 32'h0BAD_F00D, 0, 1, 0, 0, 0));
    reset_during_store(mk(1, 32'h0000_0020, 32'h5555_AAAA, 0, 1, 0, 0, 0), 2, "rst_busy");
    reset_during_store(mk(1, 32'h0000_0010, 32'h7777_7777, 0, 1, 0, 0, 0), 1, "rst_idle");
    run(mk(1, 32'h0000_0020, 0, 1, 0, 5'd6, 1, 0));
    run(mk(1, 32'h0000_0010, 0, 1, 0, 5'd8, 1, 0));
    run(mk(0, 0, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
